// File: rtl/mod60_pkg.sv
// Shared definitions for the mod-60 run controller.
//   - state_e    : FSM state encodings (value is driven out on state_o)
//   - ONES_MAX / TENS_MAX : BCD digit limits for a 00..59 count
//   - bcd_inc()  : one-step BCD increment of the tens:ones pair with wrap flag
package mod60_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_SET   = 2'd3
  } state_e;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       wrap;   // set when 59 rolls over to 00
  } bcd_next_t;

  // Increment tens:ones by one. Comparisons use >= so that a corrupted digit
  // (which normal operation never produces) still folds back into range.
  function automatic bcd_next_t bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    bcd_next_t r;
    r.tens = tens;
    r.ones = ones;
    r.wrap = 1'b0;
    if (ones >= ONES_MAX) begin
      r.ones = 4'd0;
      if (tens >= TENS_MAX) begin
        r.tens = 4'd0;
        r.wrap = 1'b1;
      end else begin
        r.tens = tens + 4'd1;
      end
    end else begin
      r.ones = ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod60_run_ctrl_if.sv
// Bundle of the controller's functional signals (everything except clock/reset).
//   tick_en            : 1 Hz enable strobe into the controller
//   btn_start/set/clr  : raw active-high push-buttons
//   led1 / led2        : BCD ones / tens digit of the count
//   running            : high while the FSM is in RUN
//   carry_out          : one-cycle pulse on a RUN-tick wrap 59 -> 00
//   state_o            : current FSM state code
// master = environment driving buttons/strobe, slave = the controller.
interface mod60_run_ctrl_if;
  logic       tick_en;
  logic       btn_start;
  logic       btn_set;
  logic       btn_clr;
  logic [3:0] led1;
  logic [3:0] led2;
  logic       running;
  logic       carry_out;
  logic [1:0] state_o;

  modport master (
    output tick_en, btn_start, btn_set, btn_clr,
    input  led1, led2, running, carry_out, state_o
  );

  modport slave (
    input  tick_en, btn_start, btn_set, btn_clr,
    output led1, led2, running, carry_out, state_o
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on an accepted 0->1 level change.
//   clki     : system clock
//   rs       : asynchronous active-low reset (level taken as released)
//   btn_raw  : raw asynchronous button input
//   press_o  : registered one-cycle pulse, DEB_CYCLES+2 clocks after a clean edge
module btn_debounce #(
  parameter int DEB_CYCLES = 20,
  parameter int DEB_W      = 5
) (
  input  logic clki,
  input  logic rs,
  input  logic btn_raw,
  output logic press_o
);

  // The accepted level flips on the DEB_CYCLES-th consecutive differing sample,
  // i.e. when the counter already holds DEB_CYCLES-1.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             meta_q,  meta_d;
  logic             sync_q,  sync_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [DEB_W-1:0] cnt_q,   cnt_d;

  // Synchronizer, stability counter and level/pulse generation.
  always_comb begin
    meta_d  = btn_raw;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync_q == level_q) begin
      cnt_d = {DEB_W{1'b0}};
    end else if (cnt_q == DEB_LAST) begin
      cnt_d   = {DEB_W{1'b0}};
      level_d = sync_q;
      press_d = sync_q;   // only a rising accepted level yields a pulse
    end else begin
      cnt_d = cnt_q + DEB_W'(1);
    end
  end

  // State registers; reset leaves the button seen as released.
  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= {DEB_W{1'b0}};
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/mod60_run_ctrl.sv
// Run/pause/set/clear controller with an embedded BCD mod-60 counter.
//   clki : system clock, rising edge
//   rs   : asynchronous active-low reset
//   bus  : mod60_run_ctrl_if.slave -- tick strobe and raw buttons in,
//          BCD digits, running flag, carry pulse and state code out
// Per-cycle priority of actions: clr > set > start > tick_en; at most one
// count change per cycle. All outputs come straight from registers.
module mod60_run_ctrl
  import mod60_pkg::*;
#(
  parameter int DEB_CYCLES = 20,
  parameter int DEB_W      = 5
) (
  input logic              clki,
  input logic              rs,
  mod60_run_ctrl_if.slave  bus
);

  logic start_pulse;
  logic set_pulse;
  logic clr_pulse;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_start (
    .clki(clki), .rs(rs), .btn_raw(bus.btn_start), .press_o(start_pulse)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_set (
    .clki(clki), .rs(rs), .btn_raw(bus.btn_set), .press_o(set_pulse)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_clr (
    .clki(clki), .rs(rs), .btn_raw(bus.btn_clr), .press_o(clr_pulse)
  );

  state_e     state_q,   state_d;
  logic [3:0] ones_q,    ones_d;
  logic [3:0] tens_q,    tens_d;
  logic       running_q, running_d;
  logic       carry_q,   carry_d;
  bcd_next_t  bcd_nxt;

  // State and output registers.
  always_ff @(posedge clki or negedge rs) begin
    if (!rs) begin
      state_q   <= ST_IDLE;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      running_q <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      running_q <= running_d;
      carry_q   <= carry_d;
    end
  end

  // Next-state logic driven by the debounced press pulses.
  always_comb begin
    state_d = state_q;
    if (clr_pulse) begin
      state_d = ST_IDLE;
    end else if (set_pulse) begin
      case (state_q)
        ST_IDLE:  state_d = ST_SET;
        ST_RUN:   state_d = ST_SET;
        ST_PAUSE: state_d = ST_SET;
        ST_SET:   state_d = ST_PAUSE;
        default:  state_d = ST_IDLE;
      endcase
    end else if (start_pulse) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        ST_SET:   state_d = ST_SET;   // start is a count action in SET
        default:  state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Count, carry and running-flag logic.
  always_comb begin
    bcd_nxt   = bcd_inc(tens_q, ones_q);
    ones_d    = ones_q;
    tens_d    = tens_q;
    carry_d   = 1'b0;
    running_d = (state_d == ST_RUN);
    if (clr_pulse) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (set_pulse) begin
      // A set press changes state only; any coincident tick is dropped.
      ones_d = ones_q;
      tens_d = tens_q;
    end else if (start_pulse) begin
      if (state_q == ST_SET) begin
        // Manual increment wraps like a tick but never raises carry_out.
        ones_d = bcd_nxt.ones;
        tens_d = bcd_nxt.tens;
      end else begin
        ones_d = ones_q;
        tens_d = tens_q;
      end
    end else if (bus.tick_en && (state_q == ST_RUN)) begin
      ones_d  = bcd_nxt.ones;
      tens_d  = bcd_nxt.tens;
      carry_d = bcd_nxt.wrap;
    end else begin
      ones_d = ones_q;
      tens_d = tens_q;
    end
  end

  assign bus.led1      = ones_q;
  assign bus.led2      = tens_q;
  assign bus.running   = running_q;
  assign bus.carry_out = carry_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_mod60_run_ctrl.sv
// Directed bench for mod60_run_ctrl with DEB_CYCLES=4. Stimulus pushes
// hand-computed expected outputs, each tagged with the clock count at which
// it is due, into a scoreboard queue; a negedge monitor pops and compares.
module tb_mod60_run_ctrl;

  logic clki = 1'b0;
  logic rs   = 1'b1;

  mod60_run_ctrl_if bus ();

  mod60_run_ctrl #(.DEB_CYCLES(4), .DEB_W(5)) dut (
    .clki (clki),
    .rs   (rs),
    .bus  (bus)
  );

  always #5 clki = ~clki;

  // Posedge counter used to timestamp expectations.
  int cyc = 0;
  always @(posedge clki) cyc <= cyc + 1;

  typedef struct {
    int         due;
    string      nm;
    logic [3:0] l2;
    logic [3:0] l1;
    logic [1:0] st;
    logic       cry;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Queue an expectation d posedges from now, kept ordered by due cycle.
  task automatic expect_at(input int d, input string nm, input logic [3:0] l2,
                           input logic [3:0] l1, input logic [1:0] st, input logic cry);
    exp_t e;
    int   i;
    e.due = cyc + d;
    e.nm  = nm;
    e.l2  = l2;
    e.l1  = l1;
    e.st  = st;
    e.cry = cry;
    i = 0;
    while (i < sb.size() && sb[i].due <= e.due) i++;
    sb.insert(i, e);
  endtask

  // Monitor: compare every due expectation half a cycle after the edge.
  always @(negedge clki) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (mon_e.due != cyc) begin
        n_fail++;
        $display("FAIL %s: check missed, due cycle %0d, now %0d", mon_e.nm, mon_e.due, cyc);
      end else if ({bus.led2, bus.led1, bus.state_o, bus.running, bus.carry_out} !==
                   {mon_e.l2, mon_e.l1, mon_e.st, (mon_e.st == 2'd1), mon_e.cry}) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got led2=%0d led1=%0d st=%0d run=%0b cry=%0b, want led2=%0d led1=%0d st=%0d run=%0b cry=%0b",
                 mon_e.nm, cyc, bus.led2, bus.led1, bus.state_o, bus.running, bus.carry_out,
                 mon_e.l2, mon_e.l1, mon_e.st, (mon_e.st == 2'd1), mon_e.cry);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clki);
      #1;
    end
  endtask

  task automatic drive_btn(input int which, input logic v);
    case (which)
      0:       bus.btn_start = v;
      1:       bus.btn_set   = v;
      default: bus.btn_clr   = v;
    endcase
  endtask

  // Clean press: pulse lands 6 edges after the raw edge, state moves on the 7th.
  task automatic press(input int which, input string nm,
                       input logic [3:0] b2, input logic [3:0] b1, input logic [1:0] bst,
                       input logic [3:0] a2, input logic [3:0] a1, input logic [1:0] ast);
    expect_at(6, {nm, "_pre"},  b2, b1, bst, 1'b0);
    expect_at(7, {nm, "_post"}, a2, a1, ast, 1'b0);
    expect_at(8, {nm, "_hold"}, a2, a1, ast, 1'b0);
    drive_btn(which, 1'b1);
    step(8);
    drive_btn(which, 1'b0);
    step(8);
  endtask

  task automatic ticks(input int n);
    bus.tick_en = 1'b1;
    step(n);
    bus.tick_en = 1'b0;
  endtask

  initial begin
    bus.tick_en   = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_set   = 1'b0;
    bus.btn_clr   = 1'b0;
    #2 rs = 1'b0;

    // 1. Reset state, then idle ticks do nothing.
    step(2);
    expect_at(0, "reset", 4'd0, 4'd0, 2'd0, 1'b0);
    step(1);
    rs = 1'b1;
    step(1);
    ticks(10);
    expect_at(0, "idle_ticks", 4'd0, 4'd0, 2'd0, 1'b0);

    // 2. Start -> RUN with exact latency; 13 ticks -> 1:3.
    press(0, "t2_start", 4'd0, 4'd0, 2'd0, 4'd0, 4'd0, 2'd1);
    ticks(13);
    expect_at(0, "t2_13ticks", 4'd1, 4'd3, 2'd1, 1'b0);

    // 3. Wrap 59 -> 00 with one-cycle carry.
    ticks(45);
    expect_at(0, "t3_58", 4'd5, 4'd8, 2'd1, 1'b0);
    ticks(1);
    expect_at(0, "t3_59", 4'd5, 4'd9, 2'd1, 1'b0);
    ticks(1);
    expect_at(0, "t3_wrap", 4'd0, 4'd0, 2'd1, 1'b1);
    step(1);
    expect_at(0, "t3_carry_end", 4'd0, 4'd0, 2'd1, 1'b0);

    // 4. Bouncing start gives no pulse; the settled press gives exactly one toggle.
    for (int i = 0; i < 5; i++) begin
      bus.btn_start = 1'b1;
      step(2);
      bus.btn_start = 1'b0;
      step(2);
    end
    expect_at(0, "t4_bounce", 4'd0, 4'd0, 2'd1, 1'b0);
    press(0, "t4_pause", 4'd0, 4'd0, 2'd1, 4'd0, 4'd0, 2'd2);
    ticks(5);
    expect_at(0, "t4_pause_ticks", 4'd0, 4'd0, 2'd2, 1'b0);
    step(10);
    expect_at(0, "t4_one_toggle", 4'd0, 4'd0, 2'd2, 1'b0);

    // 5. SET mode manual increments across the wrap, no carry; set -> PAUSE.
    press(0, "t5_run", 4'd0, 4'd0, 2'd2, 4'd0, 4'd0, 2'd1);
    ticks(58);
    expect_at(0, "t5_58", 4'd5, 4'd8, 2'd1, 1'b0);
    press(1, "t5_set", 4'd5, 4'd8, 2'd1, 4'd5, 4'd8, 2'd3);
    ticks(3);
    expect_at(0, "t5_set_ticks", 4'd5, 4'd8, 2'd3, 1'b0);
    press(0, "t5_inc1", 4'd5, 4'd8, 2'd3, 4'd5, 4'd9, 2'd3);
    press(0, "t5_inc2", 4'd5, 4'd9, 2'd3, 4'd0, 4'd0, 2'd3);
    press(0, "t5_inc3", 4'd0, 4'd0, 2'd3, 4'd0, 4'd1, 2'd3);
    press(1, "t5_pause", 4'd0, 4'd1, 2'd3, 4'd0, 4'd1, 2'd2);

    // 6a. clr coincident with tick_en in RUN at 2:7.
    press(0, "t6_run", 4'd0, 4'd1, 2'd2, 4'd0, 4'd1, 2'd1);
    ticks(26);
    expect_at(0, "t6_27", 4'd2, 4'd7, 2'd1, 1'b0);
    expect_at(6, "t6_pre_clr",  4'd2, 4'd7, 2'd1, 1'b0);
    expect_at(7, "t6_clr",      4'd0, 4'd0, 2'd0, 1'b0);
    expect_at(8, "t6_clr_hold", 4'd0, 4'd0, 2'd0, 1'b0);
    bus.btn_clr = 1'b1;
    step(6);
    bus.tick_en = 1'b1;        // high exactly at the edge that consumes the clr pulse
    step(1);
    bus.tick_en = 1'b0;
    step(1);
    bus.btn_clr = 1'b0;
    step(8);

    // 6b. Async reset mid-debounce with start held.
    press(0, "t6_run2", 4'd0, 4'd0, 2'd0, 4'd0, 4'd0, 2'd1);
    ticks(3);
    expect_at(0, "t6_03", 4'd0, 4'd3, 2'd1, 1'b0);
    bus.btn_start = 1'b1;
    step(3);
    rs = 1'b0;
    expect_at(0, "t6_async_rst", 4'd0, 4'd0, 2'd0, 1'b0);
    step(2);
    rs = 1'b1;
    for (int d = 1; d <= 6; d++) expect_at(d, "t6_no_pulse", 4'd0, 4'd0, 2'd0, 1'b0);
    expect_at(7, "t6_new_press", 4'd0, 4'd0, 2'd1, 1'b0);
    step(8);
    bus.btn_start = 1'b0;
    step(8);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clki);
    #1;
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked, due cycle %0d, now %0d", mon_e.nm, mon_e.due, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
